// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter
// Shares one RAM read path among three requesters (key, data, min).
// A request is granted and registered, then issued as a one-cycle read strobe.
// The FSM then waits for the read-data block's done pulse, guarded by a watchdog.
// Completion goes back to the granted requester as a one-hot ack pulse.
// RR_EN selects between round-robin and fixed priority, where key is highest.

module ram_read_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 16,
    parameter bit RR_EN       = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [2:0]        i_req,
    input  logic [ADDR_W-1:0] i_addr_key,
    input  logic [ADDR_W-1:0] i_addr_data,
    input  logic [ADDR_W-1:0] i_addr_min,
    input  logic              i_done,
    output logic              o_rd_en,
    output logic [1:0]        o_sel_data_rd,
    output logic [ADDR_W-1:0] o_addr,
    output logic [2:0]        o_ack,
    output logic              o_timeout,
    output logic              o_busy
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [1:0]        r_grantIdx;
    logic [1:0]        r_rrPtr;
    logic [ADDR_W-1:0] r_addr;
    logic [WD_W-1:0]   r_wdog;
    logic              r_timeoutFlag;

    logic              w_anyReq;
    logic [1:0]        w_winIdx;
    logic [ADDR_W-1:0] w_winAddr;
    logic              w_wdogExpired;

    assign w_anyReq      = |i_req;
    assign w_wdogExpired = (r_wdog == WD_LAST);

    // Pick the winning requester: rotate from the last grant, or take the lowest set bit
    always_comb begin
        w_winIdx = 2'd0;
        if (RR_EN) begin
            case (r_rrPtr)
                2'd0: begin
                    if (i_req[1])      w_winIdx = 2'd1;
                    else if (i_req[2]) w_winIdx = 2'd2;
                    else               w_winIdx = 2'd0;
                end
                2'd1: begin
                    if (i_req[2])      w_winIdx = 2'd2;
                    else if (i_req[0]) w_winIdx = 2'd0;
                    else               w_winIdx = 2'd1;
                end
                default: begin
                    if (i_req[0])      w_winIdx = 2'd0;
                    else if (i_req[1]) w_winIdx = 2'd1;
                    else               w_winIdx = 2'd2;
                end
            endcase
        end else begin
            if (i_req[0])      w_winIdx = 2'd0;
            else if (i_req[1]) w_winIdx = 2'd1;
            else if (i_req[2]) w_winIdx = 2'd2;
        end
    end

    // Route the winner's address so it can be captured at grant time
    always_comb begin
        w_winAddr = i_addr_key;
        case (w_winIdx)
            2'd1:    w_winAddr = i_addr_data;
            2'd2:    w_winAddr = i_addr_min;
            default: w_winAddr = i_addr_key;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_stateNext;
    end

    // FSM next-state logic; done takes precedence over watchdog expiry
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  if (w_anyReq) w_stateNext = ST_ISSUE;
            ST_ISSUE: w_stateNext = ST_WAIT;
            ST_WAIT:  if (i_done || w_wdogExpired) w_stateNext = ST_DONE;
            ST_DONE:  w_stateNext = ST_IDLE;
            default:  w_stateNext = ST_IDLE;
        endcase
    end

    // Grant/address capture, watchdog counting and round-robin pointer update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grantIdx    <= 2'd0;
            r_rrPtr       <= 2'd2;
            r_addr        <= '0;
            r_wdog        <= '0;
            r_timeoutFlag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_grantIdx    <= w_winIdx;
                        r_addr        <= w_winAddr;
                        r_timeoutFlag <= 1'b0;
                        r_wdog        <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_wdog <= '0;
                end
                ST_WAIT: begin
                    if (!i_done) begin
                        if (w_wdogExpired) r_timeoutFlag <= 1'b1;
                        else               r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_rrPtr <= r_grantIdx;
                end
                default: ;
            endcase
        end
    end

    // Output decode from state and registered grant; everything is zero in IDLE
    always_comb begin
        o_rd_en       = 1'b0;
        o_sel_data_rd = 2'b00;
        o_addr        = '0;
        o_ack         = 3'b000;
        o_timeout     = 1'b0;
        o_busy        = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                o_rd_en       = 1'b1;
                o_sel_data_rd = r_grantIdx + 2'd1;
                o_addr        = r_addr;
                o_busy        = 1'b1;
            end
            ST_WAIT: begin
                o_sel_data_rd = r_grantIdx + 2'd1;
                o_addr        = r_addr;
                o_busy        = 1'b1;
            end
            ST_DONE: begin
                o_sel_data_rd = r_grantIdx + 2'd1;
                o_addr        = r_addr;
                o_busy        = 1'b1;
                o_ack         = 3'b001 << r_grantIdx;
                o_timeout     = r_timeoutFlag;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// tb_ram_read_arbiter
// Runs a round-robin instance and a fixed-priority instance side by side on shared inputs.
// Stage 1 is a per-cycle vector table, stage 2 covers the multi-cycle corner cases,
// and stage 3 is randomized traffic compared against a transaction-level model.

module tb_ram_read_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] addrKey;
    logic [7:0] addrData;
    logic [7:0] addrMin;
    logic       done;

    logic       rdEn [2];
    logic [1:0] sel  [2];
    logic [7:0] addr [2];
    logic [2:0] ack  [2];
    logic       tout [2];
    logic       busy [2];

    int checks   = 0;
    int failures = 0;

    ram_read_arbiter #(.ADDR_W(8), .TIMEOUT_CYC(TIMEOUT), .RR_EN(1'b1)) dutRr (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_addr_key(addrKey), .i_addr_data(addrData), .i_addr_min(addrMin),
        .i_done(done),
        .o_rd_en(rdEn[0]), .o_sel_data_rd(sel[0]), .o_addr(addr[0]),
        .o_ack(ack[0]), .o_timeout(tout[0]), .o_busy(busy[0])
    );

    ram_read_arbiter #(.ADDR_W(8), .TIMEOUT_CYC(TIMEOUT), .RR_EN(1'b0)) dutFixed (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_addr_key(addrKey), .i_addr_data(addrData), .i_addr_min(addrMin),
        .i_done(done),
        .o_rd_en(rdEn[1]), .o_sel_data_rd(sel[1]), .o_addr(addr[1]),
        .o_ack(ack[1]), .o_timeout(tout[1]), .o_busy(busy[1])
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Last-resort guard so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL global_guard simulation ran past its time limit");
        $fatal(1, "[TB] time limit");
    end

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [7:0] aKey;
        logic [7:0] aData;
        logic [7:0] aMin;
        logic       done;
        logic       rd;
        logic [1:0] sel;
        logic [7:0] addr;
        logic [2:0] ack;
        logic       to;
        logic       busy;
    } VecT;

    typedef struct {
        bit         active;
        int         issueAt;
        int         endAt;
        int         grantIdx;
        logic [7:0] capAddr;
        int         lastGrant;
        bit         tout;
    } ModelT;

    function automatic logic [15:0] mkExp(input logic rd, input logic [1:0] s, input logic [7:0] a,
                                          input logic [2:0] ak, input logic to, input logic b);
        return {rd, s, a, ak, to, b};
    endfunction

    function automatic logic [15:0] packOut(input int k);
        return {rdEn[k], sel[k], addr[k], ack[k], tout[k], busy[k]};
    endfunction

    task automatic applyStimulus(input logic r, input logic [2:0] q, input logic [7:0] aK,
                                 input logic [7:0] aD, input logic [7:0] aM, input logic d);
        rst      = r;
        req      = q;
        addrKey  = aK;
        addrData = aD;
        addrMin  = aM;
        done     = d;
    endtask

    task automatic checkOutput(input string name, input int k, input logic [15:0] exp);
        logic [15:0] got;
        got = packOut(k);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst=%0d got rd=%b sel=%b addr=%h ack=%b to=%b busy=%b, expected rd=%b sel=%b addr=%h ack=%b to=%b busy=%b",
                     name, k, got[15], got[14:13], got[12:5], got[4:2], got[1], got[0],
                     exp[15], exp[14:13], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic checkVal(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitRdEn(input int budget, output int cycles, output bit found);
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (rdEn[0]) found = 1'b1;
        end
    endtask

    // Four consecutive grants with requests kept up; exp0/exp1 hold 2-bit sel values, entry g at [2g+1:2g]
    task automatic grantSeq(input string name, input logic [2:0] reqFirst, input logic [2:0] reqRest,
                            input logic [7:0] exp0, input logic [7:0] exp1);
        int         cyc;
        bit         found;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [2:0] a0;
        logic [2:0] a1;
        doReset();
        req = reqFirst;
        for (int g = 0; g < 4; g++) begin
            waitRdEn(6, cyc, found);
            if (!found) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s_wait_rd_en grant=%0d no read strobe within 6 cycles", name, g);
                req = 3'b000;
                return;
            end
            checkVal({name, "_gap"}, cyc, (g == 0) ? 1 : 2);
            s0 = exp0[2*g +: 2];
            s1 = exp1[2*g +: 2];
            checkVal({name, "_sel_rr"}, int'(sel[0]), int'(s0));
            checkVal({name, "_sel_fixed"}, int'(sel[1]), int'(s1));
            checkVal({name, "_rd_fixed"}, int'(rdEn[1]), 1);
            if (g == 0) req = reqRest;
            @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            a0 = 3'b001 << (s0 - 2'd1);
            a1 = 3'b001 << (s1 - 2'd1);
            checkVal({name, "_ack_rr"}, int'(ack[0]), int'(a0));
            checkVal({name, "_ack_fixed"}, int'(ack[1]), int'(a1));
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    function automatic int pickWinner(input int last, input bit rr, input logic [2:0] r);
        int idx;
        if (rr) begin
            for (int off = 1; off <= 3; off++) begin
                idx = (last + off) % 3;
                if (r[idx]) return idx;
            end
        end else begin
            for (int i = 0; i < 3; i++) if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic ModelT resetModel();
        ModelT m;
        m.active    = 1'b0;
        m.issueAt   = -10;
        m.endAt     = -1;
        m.grantIdx  = 0;
        m.capAddr   = 8'h00;
        m.lastGrant = 2;
        m.tout      = 1'b0;
        return m;
    endfunction

    function automatic logic [15:0] modelExpect(input ModelT m, input int n);
        logic       rd;
        logic [1:0] s;
        logic [2:0] ak;
        logic       to;
        if (!m.active) return 16'h0000;
        rd = (n == m.issueAt);
        s  = 2'(m.grantIdx + 1);
        ak = (n == m.endAt) ? (3'b001 << m.grantIdx) : 3'b000;
        to = (n == m.endAt) && m.tout;
        return mkExp(rd, s, m.capAddr, ak, to, 1'b1);
    endfunction

    function automatic ModelT modelStep(input ModelT mIn, input int n, input bit rr, input logic r,
                                        input logic [2:0] q, input logic [7:0] aK, input logic [7:0] aD,
                                        input logic [7:0] aM, input logic d);
        ModelT m;
        m = mIn;
        if (r) begin
            m = resetModel();
        end else if (!m.active) begin
            if (q != 3'b000) begin
                m.grantIdx = pickWinner(m.lastGrant, rr, q);
                m.capAddr  = (m.grantIdx == 0) ? aK : (m.grantIdx == 1) ? aD : aM;
                m.issueAt  = n + 1;
                m.endAt    = -1;
                m.tout     = 1'b0;
                m.active   = 1'b1;
            end
        end else if (n == m.endAt) begin
            m.active    = 1'b0;
            m.lastGrant = m.grantIdx;
        end else if (n > m.issueAt && m.endAt < 0) begin
            if (d) begin
                m.endAt = n + 1;
                m.tout  = 1'b0;
            end else if (n - m.issueAt == TIMEOUT) begin
                m.endAt = n + 1;
                m.tout  = 1'b1;
            end
        end
        return m;
    endfunction

    // Main test sequence
    initial begin
        VecT        vecs [14];
        ModelT      mdl [2];
        int         cyc;
        int         lat;
        bit         found;
        bit         gotAck;
        logic       rRst;
        logic [2:0] rReq;
        logic       rDone;

        vecs[0]  = '{1'b0, 3'b001, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 2'b01, 8'h12, 3'b000, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 3'b001, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 2'b01, 8'h12, 3'b000, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 3'b001, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 2'b01, 8'h12, 3'b000, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 3'b001, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 2'b01, 8'h12, 3'b000, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 3'b001, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 2'b01, 8'h12, 3'b001, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 3'b000, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 3'b000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b000, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00, 3'b000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b010, 8'h34, 8'h56, 8'h00, 1'b0, 1'b1, 2'b10, 8'h56, 3'b000, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 3'b010, 8'h34, 8'h56, 8'h00, 1'b0, 1'b0, 2'b10, 8'h56, 3'b000, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 3'b010, 8'h34, 8'h56, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 3'b000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 8'h9A, 8'h56, 8'h00, 1'b0, 1'b1, 2'b01, 8'h9A, 3'b000, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 3'b011, 8'h9A, 8'h56, 8'h00, 1'b1, 1'b0, 2'b01, 8'h9A, 3'b000, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 3'b011, 8'h9A, 8'h56, 8'h00, 1'b1, 1'b0, 2'b01, 8'h9A, 3'b001, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 3'b000, 8'h9A, 8'h56, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 3'b000, 1'b0, 1'b0};

        applyStimulus(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) checkOutput("reset_state", k, 16'h0000);

        // Each row: drive inputs at a falling edge, check the state after the next rising edge
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].aKey, vecs[i].aData, vecs[i].aMin, vecs[i].done);
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                checkOutput($sformatf("vector_%0d", i), k,
                            mkExp(vecs[i].rd, vecs[i].sel, vecs[i].addr, vecs[i].ack, vecs[i].to, vecs[i].busy));
        end

        grantSeq("rr_all", 3'b111, 3'b111, 8'b01_11_10_01, 8'b01_01_01_01);
        grantSeq("prio", 3'b110, 3'b111, 8'b10_01_11_10, 8'b01_01_01_10);

        // Watchdog abort, then a late done arriving in IDLE
        doReset();
        req     = 3'b100;
        addrMin = 8'hC3;
        waitRdEn(6, cyc, found);
        checkVal("timeout_rd_en_seen", int'(found), 1);
        checkVal("timeout_sel", int'(sel[0]), 3);
        checkVal("timeout_addr", int'(addr[0]), 8'hC3);
        lat    = 0;
        gotAck = 1'b0;
        while (!gotAck && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack[0] != 3'b000) gotAck = 1'b1;
        end
        checkVal("timeout_latency", lat, TIMEOUT + 1);
        for (int k = 0; k < 2; k++) begin
            checkVal($sformatf("timeout_ack_%0d", k), int'(ack[k]), 4);
            checkVal($sformatf("timeout_flag_%0d", k), int'(tout[k]), 1);
        end
        req = 3'b000;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        for (int k = 0; k < 2; k++) checkOutput("late_done_idle", k, 16'h0000);
        @(negedge clk);
        for (int k = 0; k < 2; k++) checkOutput("late_done_after", k, 16'h0000);

        // Done on the watchdog's final WAIT cycle: done wins, no timeout flag
        req     = 3'b100;
        addrMin = 8'h7E;
        waitRdEn(6, cyc, found);
        checkVal("race_rd_en_seen", int'(found), 1);
        repeat (TIMEOUT) @(negedge clk);
        for (int k = 0; k < 2; k++) checkOutput("race_last_wait", k, mkExp(1'b0, 2'b11, 8'h7E, 3'b000, 1'b0, 1'b1));
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        for (int k = 0; k < 2; k++) checkOutput("race_ack", k, mkExp(1'b0, 2'b11, 8'h7E, 3'b100, 1'b0, 1'b1));
        req = 3'b000;
        @(negedge clk);

        // Randomized traffic against the transaction-level model
        for (int k = 0; k < 2; k++) mdl[k] = resetModel();
        applyStimulus(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        rReq = 3'b000;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) checkOutput("random", k, modelExpect(mdl[k], n));
            rRst  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) rReq = 3'($urandom_range(0, 7));
            rDone = ($urandom_range(0, 7) == 0);
            applyStimulus(rRst, rReq, 8'($urandom), 8'($urandom), 8'($urandom), rDone);
            for (int k = 0; k < 2; k++)
                mdl[k] = modelStep(mdl[k], n, (k == 0), rRst, rReq, addrKey, addrData, addrMin, rDone);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
